// File: rtl/exc_flush_ctrl_if.sv
// Redirect handshake between the exception flush controller and the fetch stage.
// The controller drives the request side (valid + target PC), fetch drives ready.
interface exc_flush_ctrl_if;
   localparam int unsigned PC_W = 32;

   logic              fs_redirect_valid;
   logic [PC_W-1:0]   fs_redirect_pc;
   logic              fs_redirect_ready;

   // Controller side: issues the redirect and waits for fetch to take it
   modport master (
      output fs_redirect_valid,
      output fs_redirect_pc,
      input  fs_redirect_ready
   );

   // Fetch side: observes the redirect and accepts it
   modport slave (
      input  fs_redirect_valid,
      input  fs_redirect_pc,
      output fs_redirect_ready
   );
endinterface

// File: rtl/exc_flush_ctrl.sv
// Exception / ERTN pipeline recovery sequencer.
// On a WB commit of an exception or ERTN it latches the redirect target
// (EENTRY or ERA), kills all pipeline stages for at least two cycles and
// holds a valid/ready redirect to fetch until accepted. It also produces a
// registered interrupt-take flag for decode.
// Optional event counters are built when EXC_FLUSH_CNT_EN is defined.
module exc_flush_ctrl #(
   parameter logic [31:0]  RESET_PC = 32'h1c000000,
   parameter int unsigned  CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_ex,
   input  logic                    ertn_flush,
   input  logic [5:0]              wb_ecode,
   input  logic [31:0]             csr_eentry,
   input  logic [31:0]             csr_era,
   input  logic                    csr_crmd_ie,
   input  logic [12:0]             int_pending,
   output logic                    flush,
   output logic                    has_int,
   output logic                    ctrl_busy,
   exc_flush_ctrl_if.master        redir
`ifdef EXC_FLUSH_CNT_EN
   ,
   output logic [CNT_W-1:0]        exc_cnt,
   output logic [CNT_W-1:0]        int_cnt,
   output logic [CNT_W-1:0]        ertn_cnt
`endif
);

   localparam int unsigned PC_W    = 32;
   localparam int unsigned ECODE_W = 6;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLUSH    = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_accept;
   logic [PC_W-1:0]     w_target;
   logic                w_handshake;

   logic                r_flush;
   logic                r_valid;
   logic [PC_W-1:0]     r_pc;
   logic                r_has_int;

   // Exception has priority over ERTN when both commit together
   assign w_target    = wb_ex ? csr_eentry : csr_era;
   assign w_handshake = r_valid & redir.fs_redirect_ready;

   // Next-state decode; commit requests are only honoured from IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (wb_ex || ertn_flush) begin
               w_accept    = 1'b1;
               w_state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            w_state_nxt = S_REDIRECT;
         end
         S_REDIRECT: begin
            if (w_handshake) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and registered outputs derived from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_flush <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_flush <= (w_state_nxt != S_IDLE);
         r_valid <= (w_state_nxt == S_REDIRECT);
      end
   end

   // Redirect target: captured once per accepted request, held afterwards
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (w_accept) begin
         r_pc <= w_target;
      end
   end

   // Interrupt-take flag, suppressed while a commit is requested or recovery runs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_has_int <= 1'b0;
      end else begin
         r_has_int <= (|int_pending) & csr_crmd_ie & (r_state == S_IDLE)
                      & ~wb_ex & ~ertn_flush;
      end
   end

   assign flush                   = r_flush;
   assign redir.fs_redirect_valid = r_valid;
   assign redir.fs_redirect_pc    = r_pc;
   assign has_int                 = r_has_int;
   assign ctrl_busy               = (r_state != S_IDLE);

`ifdef EXC_FLUSH_CNT_EN
   logic                r_ex_sel;
   logic                w_ecode_is_int;
   logic [CNT_W-1:0]    r_exc_cnt;
   logic [CNT_W-1:0]    r_int_cnt;
   logic [CNT_W-1:0]    r_ertn_cnt;

   assign w_ecode_is_int = (wb_ecode == ECODE_W'(0));

   // Event counters: only IDLE-accepted requests count, wrapping naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         r_exc_cnt  <= '0;
         r_int_cnt  <= '0;
         r_ertn_cnt <= '0;
         r_ex_sel   <= 1'b0;
      end else if (w_accept) begin
         r_ex_sel <= wb_ex;
         if (wb_ex && !w_ecode_is_int) begin
            r_exc_cnt <= r_exc_cnt + CNT_W'(1);
         end
         if (wb_ex && w_ecode_is_int) begin
            r_int_cnt <= r_int_cnt + CNT_W'(1);
         end
         if (!wb_ex) begin
            r_ertn_cnt <= r_ertn_cnt + CNT_W'(1);
         end
      end
   end

   assign exc_cnt  = r_exc_cnt;
   assign int_cnt  = r_int_cnt;
   assign ertn_cnt = r_ertn_cnt;

   // Last accepted request type is kept only for debug visibility
   logic w_unused_sel;
   assign w_unused_sel = r_ex_sel;
`else
   // Exception code only feeds the counters; keep it explicitly consumed
   logic w_unused_ecode;
   assign w_unused_ecode = (^wb_ecode) ^ (CNT_W == 32'd0) ^ (ECODE_W == 32'd0);
`endif

endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
- Sequences pipeline recovery after an exception or ERTN commits in the write-back stage.
- Latches the redirect target (CSR EENTRY or ERA), broadcasts a flush to all stages, and holds a valid/ready redirect handshake with the fetch stage until it accepts the new PC.
- Also qualifies pending interrupts into a registered has_int flag for decode to tag onto the next instruction.

Parameters:
- RESET_PC, 32'h1c000000, value of fs_redirect_pc out of reset.
- CNT_W, 32, width of the optional event counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wb_ex  input  1  an exception commits in WB this cycle.
- ertn_flush  input  1  an ERTN commits in WB this cycle.
- wb_ecode  input  6  exception code of the committing exception; 6'h0 means interrupt.
- csr_eentry  input  32  current CSR EENTRY value.
- csr_era  input  32  current CSR ERA value.
- csr_crmd_ie  input  1  CRMD.IE, the global interrupt enable.
- int_pending  input  13  ESTAT.IS & ECFG.LIE, bitwise.
- flush  output  1  kill-all to IF/ID/EX/MEM/WB valid registers.
- fs_redirect_valid  output  1  redirect request to fetch.
- fs_redirect_pc  output  32  redirect target.
- fs_redirect_ready  input  1  fetch accepts the redirect.
- has_int  output  1  registered interrupt-take flag to ID.
- ctrl_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, flush=0, fs_redirect_valid=0, fs_redirect_pc=RESET_PC, has_int=0, ctrl_busy=0. Optional counters reset to 0.
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE, wb_ex=1: latch target=csr_eentry, next state FLUSH.
- IDLE, ertn_flush=1 and wb_ex=0: latch target=csr_era, next state FLUSH.
- IDLE, wb_ex and ertn_flush both high: wb_ex wins, target=csr_eentry.
- FLUSH: flush=1, fs_redirect_valid=0. Always advances to REDIRECT after one cycle.
- REDIRECT: flush=1, fs_redirect_valid=1, fs_redirect_pc=latched target.
  - fs_redirect_valid & fs_redirect_ready at a posedge: next state IDLE, so both flush and valid are 0 the following cycle.
  - Ready held high on REDIRECT entry completes the handshake in the first REDIRECT cycle.
- fs_redirect_pc holds the last target after the handshake; it changes only on a new latch or reset.
- Latency: wb_ex sampled at edge T gives flush=1 from T+1 and fs_redirect_valid=1 from T+2. Minimum occupancy is 2 cycles, then back in IDLE.
- wb_ex and ertn_flush are ignored in FLUSH and REDIRECT; the target is not relatched.
- The target is passed unmodified; no alignment masking.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- has_int register: next value = (|int_pending) & csr_crmd_ie & (state==IDLE) & ~wb_ex & ~ertn_flush. It is therefore forced to 0 for the cycle after any commit request and throughout FLUSH/REDIRECT.
- Reset asserted in any state returns the block to IDLE with reset values at the next edge. A pending handshake is abandoned.
- ctrl_busy = (state != IDLE).

Optional Feature:
- Macro: EXC_FLUSH_CNT_EN.
- Defined: adds outputs exc_cnt, int_cnt and ertn_cnt, each CNT_W bits. Each increments by 1 only on an IDLE-accepted request:
  - exc_cnt on wb_ex with wb_ecode != 0.
  - int_cnt on wb_ex with wb_ecode == 0.
  - ertn_cnt on an accepted ertn_flush.
  - All counters wrap modulo 2^CNT_W. Ignored (non-IDLE) requests do not count.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles -> fs_redirect_pc=32'h1c000000, flush=0, fs_redirect_valid=0, has_int=0.
- csr_eentry=32'h1c008000, wb_ex pulse at T with fs_redirect_ready tied 1 -> flush high at T+1 and T+2, valid high only at T+2 with pc 32'h1c008000, IDLE at T+3.
- ertn_flush pulse, csr_era=32'h1c0001f4, ready low for 4 cycles then high -> valid and flush held 4 cycles, pc stable at 32'h1c0001f4, one cycle with valid & ready, then both drop.
- wb_ex and ertn_flush same cycle (eentry=32'h1c008000, era=32'h1c000100) -> pc 32'h1c008000; a second wb_ex during REDIRECT is ignored, with no relatch and no counter increment.
- int_pending=13'h800, crmd_ie=1 in IDLE -> has_int=1 next cycle. crmd_ie=0 -> has_int=0. wb_ex with wb_ecode=0 -> has_int=0 from the next cycle through the flush, and int_cnt+1 when EXC_FLUSH_CNT_EN is defined.
- reset asserted in REDIRECT with ready low -> next cycle valid=0, flush=0, pc=32'h1c000000, ctrl_busy=0.
